// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: drives a shared 16x16 unsigned pipelined multiplier to build
// 32x32 products (low word or full 64 bits, with signed correction).
module mul_seq_ctrl #(
   parameter int unsigned MUL_LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_hi,
   output logic [31:0] rsp_lo,
   output logic [15:0] mul_a,
   output logic [15:0] mul_b,
   output logic        mul_issue,
   input  logic [31:0] mul_p
);

   localparam int unsigned HALF_W = 16;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned ACC_W  = 64;
   localparam int unsigned IDX_W  = 2;
   localparam int unsigned SH_W   = 2;
   localparam int unsigned LAT    = MUL_LATENCY;

   typedef enum logic [1:0] {
      OP_MUL    = 2'b00,
      OP_MULXUU = 2'b01,
      OP_MULXSU = 2'b10,
      OP_MULXSS = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      IDLE, ISSUE, DRAIN, CORR, DONE
   } state_e;

   state_e                state_q, state_d;
   op_e                   op_q, op_d;
   logic [WORD_W-1:0]     a_q, a_d, b_q, b_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [ACC_W-1:0]      acc_q, acc_d;
   logic [HALF_W-1:0]     mul_a_q, mul_a_d, mul_b_q, mul_b_d;
   logic                  mul_issue_q, mul_issue_d;
   // shift code travelling with the issued operands: 0 -> 0, 1 -> 16, 2 -> 32
   logic [SH_W-1:0]       mul_sh_q, mul_sh_d;
   logic [LAT-1:0]        tag_vld_q;
   logic [LAT-1:0][SH_W-1:0] tag_sh_q;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [WORD_W-1:0]     rsp_hi_q, rsp_hi_d, rsp_lo_q, rsp_lo_d;

   logic [LAT:0]            vld_chain;
   logic [LAT:0][SH_W-1:0]  sh_chain;
   logic [IDX_W-1:0]        last_idx;
   logic [WORD_W-1:0]       corr_hi;

   // Tag chain: index 0 is the tag beside mul_a/mul_b, index LAT matches mul_p.
   always_comb begin
      vld_chain = {tag_vld_q, mul_issue_q};
      sh_chain  = {tag_sh_q, mul_sh_q};
   end

   // Next-state, partial-product issue, accumulation and correction.
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      idx_d       = idx_q;
      acc_d       = acc_q;
      mul_a_d     = mul_a_q;
      mul_b_d     = mul_b_q;
      mul_issue_d = 1'b0;
      mul_sh_d    = mul_sh_q;
      rsp_valid_d = 1'b0;
      rsp_hi_d    = rsp_hi_q;
      rsp_lo_d    = rsp_lo_q;
      last_idx    = (op_q == OP_MUL) ? IDX_W'(2) : IDX_W'(3);
      corr_hi     = acc_q[ACC_W-1:WORD_W];

      if (vld_chain[LAT]) begin
         acc_d = acc_q + (ACC_W'(mul_p) << {sh_chain[LAT], 4'b0000});
      end

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               op_d        = op_e'(req_op);
               a_d         = req_a;
               b_d         = req_b;
               acc_d       = '0;
               mul_a_d     = req_a[HALF_W-1:0];
               mul_b_d     = req_b[HALF_W-1:0];
               mul_sh_d    = SH_W'(0);
               mul_issue_d = 1'b1;
               idx_d       = IDX_W'(1);
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
            mul_issue_d = 1'b1;
            idx_d       = IDX_W'(idx_q + IDX_W'(1));
            case (idx_q)
               IDX_W'(0): begin
                  mul_a_d  = a_q[HALF_W-1:0];
                  mul_b_d  = b_q[HALF_W-1:0];
                  mul_sh_d = SH_W'(0);
               end
               IDX_W'(1): begin
                  mul_a_d  = a_q[WORD_W-1:HALF_W];
                  mul_b_d  = b_q[HALF_W-1:0];
                  mul_sh_d = SH_W'(1);
               end
               IDX_W'(2): begin
                  mul_a_d  = a_q[HALF_W-1:0];
                  mul_b_d  = b_q[WORD_W-1:HALF_W];
                  mul_sh_d = SH_W'(1);
               end
               default: begin
                  mul_a_d  = a_q[WORD_W-1:HALF_W];
                  mul_b_d  = b_q[WORD_W-1:HALF_W];
                  mul_sh_d = SH_W'(2);
               end
            endcase
            if (idx_q == last_idx) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            // only the emerging tag (accumulated at this edge) may remain
            if (!(|vld_chain[LAT-1:0])) begin
               state_d = CORR;
            end
         end
         CORR: begin
            if ((op_q == OP_MULXSU || op_q == OP_MULXSS) && a_q[WORD_W-1]) begin
               corr_hi = corr_hi - b_q;
            end
            if (op_q == OP_MULXSS && b_q[WORD_W-1]) begin
               corr_hi = corr_hi - a_q;
            end
            if (op_q == OP_MUL) begin
               corr_hi = '0;
            end
            rsp_hi_d    = corr_hi;
            rsp_lo_d    = acc_q[WORD_W-1:0];
            rsp_valid_d = 1'b1;
            state_d     = DONE;
         end
         DONE: begin
            rsp_valid_d = 1'b1;
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, operand, accumulator, tag pipeline and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         op_q        <= OP_MUL;
         a_q         <= '0;
         b_q         <= '0;
         idx_q       <= '0;
         acc_q       <= '0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         mul_issue_q <= 1'b0;
         mul_sh_q    <= '0;
         tag_vld_q   <= '0;
         tag_sh_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_hi_q    <= '0;
         rsp_lo_q    <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         idx_q       <= idx_d;
         acc_q       <= acc_d;
         mul_a_q     <= mul_a_d;
         mul_b_q     <= mul_b_d;
         mul_issue_q <= mul_issue_d;
         mul_sh_q    <= mul_sh_d;
         tag_vld_q   <= vld_chain[LAT-1:0];
         tag_sh_q    <= sh_chain[LAT-1:0];
         rsp_valid_q <= rsp_valid_d;
         rsp_hi_q    <= rsp_hi_d;
         rsp_lo_q    <= rsp_lo_d;
      end
   end

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_hi    = rsp_hi_q;
   assign rsp_lo    = rsp_lo_q;
   assign mul_a     = mul_a_q;
   assign mul_b     = mul_b_q;
   assign mul_issue = mul_issue_q;

endmodule
